snap_axi_id_remap: RTL
======================

Name: snap_axi_id_remap

Overview:
- Parametrised successor to the fixed NVDLA-to-host-memory AXI glue. Handles one request/response channel pair: AR/R when RSP_HAS_LAST=1, AW/B when RSP_HAS_LAST=0. The action instantiates it twice.
- Compresses wide core AXI IDs onto the narrow host ID space through a tracked remap table.
- Widens address and length, and drives legal burst and size instead of tie-offs.
- Data beats (R data, W channel) bypass this block.

Parameters:
- CORE_ID_WIDTH, 8, core-side ID width
- HOST_ID_WIDTH, 1, host-side ID width; slot table depth NSLOT = 2**HOST_ID_WIDTH
- CORE_ADDR_WIDTH, 32, core address width
- HOST_ADDR_WIDTH, 64, host address width (must be >= CORE_ADDR_WIDTH)
- CORE_LEN_WIDTH, 4, core burst length width
- HOST_DATA_WIDTH, 512, host data width; sets host size = log2(HOST_DATA_WIDTH/8)
- MAX_OUTST, 15, maximum outstanding transactions per slot
- RSP_HAS_LAST, 1, 1 = R channel (release on last beat), 0 = B channel (every response releases)

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  asynchronous active-high reset
- base_addr_hi  in  HOST_ADDR_WIDTH-CORE_ADDR_WIDTH  upper address bits prepended to every request
- core_req_valid  in  1  core AR/AW valid
- core_req_ready  out  1  core AR/AW ready
- core_req_id  in  CORE_ID_WIDTH  core transaction ID
- core_req_addr  in  CORE_ADDR_WIDTH  core address
- core_req_len  in  CORE_LEN_WIDTH  core burst length minus 1
- host_req_valid  out  1  host AR/AW valid
- host_req_ready  in  1  host AR/AW ready
- host_req_id  out  HOST_ID_WIDTH  remapped ID
- host_req_addr  out  HOST_ADDR_WIDTH  widened address
- host_req_len  out  8  zero-extended length
- host_req_burst  out  2  constant 2'b01 (INCR)
- host_req_size  out  3  constant log2(HOST_DATA_WIDTH/8)
- host_rsp_valid  in  1  host R/B valid
- host_rsp_ready  out  1  host R/B ready
- host_rsp_id  in  HOST_ID_WIDTH  host response ID
- host_rsp_last  in  1  R last; ignored when RSP_HAS_LAST=0
- core_rsp_valid  out  1  core R/B valid
- core_rsp_ready  in  1  core R/B ready
- core_rsp_id  out  CORE_ID_WIDTH  restored core ID
- busy  out  1  any slot has a nonzero count, or the output register is full
- id_err  out  1  sticky flag: response arrived for an unallocated slot

Behaviour:
- Reset: all slots invalid with count 0. host_req_valid=0, id_err=0, busy=0, core_req_ready=0 while ap_rst is high. All registered outputs are 0.
- Slot state: valid bit, core_id, count (range 0..MAX_OUTST).
- Slot selection for a core request uses pre-edge state:
  - If a valid slot holds the same core_id, that slot is used (keeps AXI same-ID ordering).
  - If that slot's count == MAX_OUTST, stall. Never use a second slot for the same core_id.
  - Otherwise use the lowest-index invalid slot.
  - If no slot is available, stall.
- core_req_ready = slot available AND (output register empty OR host_req_ready). The request path is one register stage, full throughput.
- Accept (core_req_valid & core_req_ready):
  - The slot becomes valid, core_id is stored, count increments.
  - The output register loads the request. host_req_valid rises the next cycle, so latency is 1 cycle.
- Host request field values:
  - host_req_addr = {base_addr_hi, core_req_addr}.
  - host_req_len = zero-extended core_req_len.
  - host_req_id = slot index.
  - The output holds stable while valid & !ready.
- Response path is combinational:
  - core_rsp_valid = host_rsp_valid; host_rsp_ready = core_rsp_ready.
  - core_rsp_id = slot[host_rsp_id].core_id.
- Release: on a response handshake with (host_rsp_last OR RSP_HAS_LAST==0), that slot's count decrements. When the count reaches 0 the slot goes invalid.
- Same cycle, same slot, accept and release: count is unchanged and the slot stays valid.
- Same cycle, release frees slot A: accept cannot pick A that cycle; A is usable from the next cycle.
- Response handshake to a slot that is invalid or has count 0:
  - id_err is set (sticky until reset).
  - The response is still forwarded with core_rsp_id = 0.
  - No count changes.
- Reset asserted mid-operation: everything returns to reset values immediately. Outstanding host transactions are abandoned; the system must reset both sides together.

Decomposition:
- Package snap_axi_pkg holds:
  - AXI_BURST_INCR = 2'b01
  - a function computing log2 of bytes per beat
  - a slot-state struct {valid, core_id, count}
- Sub-module snap_id_slot_table owns the NSLOT slots, the match/free priority encoder, and the alloc/release update. The top level keeps the request register and the response muxing.

Test Plan:
- Single read, core id 8'h5A, addr 32'h1000, len 4'hF, base_addr_hi 32'h1 -> next cycle host_req_addr 64'h1_0000_1000, len 8'h0F, burst 01, size 3'b110, id 0; 16-beat R with id 0 returns core_rsp_id 8'h5A; busy drops after the last beat.
- HOST_ID_WIDTH=1, three distinct core IDs 1, 2, 3 issued back to back -> IDs 1 and 2 map to host ids 0 and 1; ID 3 stalls (core_req_ready=0) until a last-beat response on id 0, then is accepted the cycle after that release as host id 0.
- MAX_OUTST=2, four requests with core id 7 -> two accepted on slot 0; the third stalls even though slot 1 is free; it is accepted the cycle after a release.
- Slot count 1 and a new same-ID request accepted in the same cycle the last beat returns -> count stays 1, slot stays valid, the next response maps correctly.
- B-channel instance (RSP_HAS_LAST=0), response with host_rsp_id 1 while slot 1 is invalid -> id_err=1, core_rsp_id 0, counts unchanged; ap_rst pulse -> id_err=0, busy=0, host_req_valid=0.
- host_req_ready held low for 5 cycles with a request pending -> host_req_* stable, core_req_ready=0; full throughput resumes once ready returns.

Source files
------------

// File: rtl/snap_axi_pkg.sv
// Shared constants, types and helpers for the AXI ID remap glue.
// The slot fields are sized for the widest supported core ID and count; narrower configurations leave the upper bits at zero.
package snap_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         SLOT_ID_MAX_W  = 32;
    localparam int         SLOT_CNT_MAX_W = 8;

    typedef struct packed {
        logic                      valid;
        logic [SLOT_ID_MAX_W-1:0]  core_id;
        logic [SLOT_CNT_MAX_W-1:0] count;
    } slot_t;

    // AXI AxSIZE encoding: log2 of the number of bytes per beat.
    function automatic logic [2:0] axi_size_of(input int data_width);
        logic [2:0] size;
        size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((data_width / 8) == (1 << i)) begin
                size = 3'(i);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/snap_axi_id_remap_if.sv
// Request/response channel pair between the core, the remap block and the host.
// The slave modport is the remap block's view; the master modport drives the core request and host response sides.
interface snap_axi_id_remap_if #(
    parameter int CORE_ID_WIDTH   = 8,
    parameter int HOST_ID_WIDTH   = 1,
    parameter int CORE_ADDR_WIDTH = 32,
    parameter int HOST_ADDR_WIDTH = 64,
    parameter int CORE_LEN_WIDTH  = 4
);
    logic                       core_req_valid;
    logic                       core_req_ready;
    logic [CORE_ID_WIDTH-1:0]   core_req_id;
    logic [CORE_ADDR_WIDTH-1:0] core_req_addr;
    logic [CORE_LEN_WIDTH-1:0]  core_req_len;

    logic                       host_req_valid;
    logic                       host_req_ready;
    logic [HOST_ID_WIDTH-1:0]   host_req_id;
    logic [HOST_ADDR_WIDTH-1:0] host_req_addr;
    logic [7:0]                 host_req_len;
    logic [1:0]                 host_req_burst;
    logic [2:0]                 host_req_size;

    logic                       host_rsp_valid;
    logic                       host_rsp_ready;
    logic [HOST_ID_WIDTH-1:0]   host_rsp_id;
    logic                       host_rsp_last;

    logic                       core_rsp_valid;
    logic                       core_rsp_ready;
    logic [CORE_ID_WIDTH-1:0]   core_rsp_id;

    modport slave (
        input  core_req_valid, core_req_id, core_req_addr, core_req_len,
        output core_req_ready,
        output host_req_valid, host_req_id, host_req_addr, host_req_len, host_req_burst, host_req_size,
        input  host_req_ready,
        input  host_rsp_valid, host_rsp_id, host_rsp_last,
        output host_rsp_ready,
        output core_rsp_valid, core_rsp_id,
        input  core_rsp_ready
    );

    modport master (
        output core_req_valid, core_req_id, core_req_addr, core_req_len,
        input  core_req_ready,
        input  host_req_valid, host_req_id, host_req_addr, host_req_len, host_req_burst, host_req_size,
        output host_req_ready,
        output host_rsp_valid, host_rsp_id, host_rsp_last,
        input  host_rsp_ready,
        input  core_rsp_valid, core_rsp_id,
        output core_rsp_ready
    );

endinterface

// File: rtl/snap_id_slot_table.sv
// Remap slot table: same-ID match / lowest-free selection and per-slot outstanding counts.
// Selection is combinational on pre-edge state; alloc and release take effect at the clock edge.
module snap_id_slot_table
    import snap_axi_pkg::*;
#(
    parameter int CORE_ID_WIDTH = 8,
    parameter int HOST_ID_WIDTH = 1,
    parameter int MAX_OUTST     = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CORE_ID_WIDTH-1:0] req_id_i,
    output logic                     avail_o,
    output logic [HOST_ID_WIDTH-1:0] alloc_slot_o,
    input  logic                     alloc_i,
    input  logic [HOST_ID_WIDTH-1:0] rsp_slot_i,
    output logic                     rsp_bad_o,
    output logic [CORE_ID_WIDTH-1:0] rsp_core_id_o,
    input  logic                     release_i,
    output logic                     busy_o
);
    localparam int                        NSLOT   = 2 ** HOST_ID_WIDTH;
    localparam logic [SLOT_CNT_MAX_W-1:0] CNT_MAX = SLOT_CNT_MAX_W'(MAX_OUTST);
    localparam logic [SLOT_CNT_MAX_W-1:0] CNT_ONE = SLOT_CNT_MAX_W'(1);

    slot_t                    slot_q [NSLOT];
    slot_t                    slot_d [NSLOT];
    slot_t                    rsp_slot;
    logic [SLOT_ID_MAX_W-1:0] req_id_ext;
    logic                     match;
    logic                     free;
    logic [HOST_ID_WIDTH-1:0] match_idx;
    logic [HOST_ID_WIDTH-1:0] free_idx;
    logic [NSLOT-1:0]         inc_v;
    logic [NSLOT-1:0]         dec_v;

    assign req_id_ext    = SLOT_ID_MAX_W'(req_id_i);
    assign rsp_slot      = slot_q[rsp_slot_i];
    assign rsp_bad_o     = !rsp_slot.valid || (rsp_slot.count == '0);
    assign rsp_core_id_o = rsp_bad_o ? '0 : rsp_slot.core_id[CORE_ID_WIDTH-1:0];

    // A matching slot always wins, even when full: a second slot would break same-ID ordering.
    always_comb begin
        match     = 1'b0;
        free      = 1'b0;
        match_idx = '0;
        free_idx  = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (slot_q[i].valid && (slot_q[i].core_id == req_id_ext)) begin
                match     = 1'b1;
                match_idx = HOST_ID_WIDTH'(i);
            end
            if (!slot_q[i].valid) begin
                free     = 1'b1;
                free_idx = HOST_ID_WIDTH'(i);
            end
        end
        alloc_slot_o = match ? match_idx : free_idx;
        avail_o      = match ? (slot_q[match_idx].count != CNT_MAX) : free;
    end

    always_comb begin
        inc_v  = '0;
        dec_v  = '0;
        busy_o = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            inc_v[i]  = alloc_i && (alloc_slot_o == HOST_ID_WIDTH'(i));
            dec_v[i]  = release_i && (rsp_slot_i == HOST_ID_WIDTH'(i));
            slot_d[i] = slot_q[i];
            if (slot_q[i].count != '0) begin
                busy_o = 1'b1;
            end
            if (inc_v[i] && !dec_v[i]) begin
                slot_d[i].valid   = 1'b1;
                slot_d[i].core_id = req_id_ext;
                slot_d[i].count   = slot_q[i].count + CNT_ONE;
            end else if (dec_v[i] && !inc_v[i]) begin
                slot_d[i].count = slot_q[i].count - CNT_ONE;
                if (slot_q[i].count == CNT_ONE) begin
                    slot_d[i].valid   = 1'b0;
                    slot_d[i].core_id = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

endmodule

// File: rtl/snap_axi_id_remap.sv
// Core-to-host AXI request remap: narrows IDs through a slot table, widens address/len; 1-cycle request latency.
// Request stage is a single full-throughput register stalled by host ready; the response path is combinational.
module snap_axi_id_remap
    import snap_axi_pkg::*;
#(
    parameter int CORE_ID_WIDTH   = 8,
    parameter int HOST_ID_WIDTH   = 1,
    parameter int CORE_ADDR_WIDTH = 32,
    parameter int HOST_ADDR_WIDTH = 64,
    parameter int CORE_LEN_WIDTH  = 4,
    parameter int HOST_DATA_WIDTH = 512,
    parameter int MAX_OUTST       = 15,
    parameter int RSP_HAS_LAST    = 1
) (
    input  logic                                       ap_clk,
    input  logic                                       ap_rst,
    input  logic [HOST_ADDR_WIDTH-CORE_ADDR_WIDTH-1:0] base_addr_hi,
    snap_axi_id_remap_if.slave                         bus,
    output logic                                       busy,
    output logic                                       id_err
);
    localparam logic [2:0] HOST_SIZE = axi_size_of(HOST_DATA_WIDTH);

    logic                       avail;
    logic                       accept;
    logic                       rsp_hs;
    logic                       rsp_bad;
    logic                       rsp_release;
    logic                       slots_busy;
    logic [HOST_ID_WIDTH-1:0]   alloc_slot;
    logic [CORE_ID_WIDTH-1:0]   rsp_core_id;

    logic                       req_vld_q,  req_vld_d;
    logic [HOST_ID_WIDTH-1:0]   req_id_q,   req_id_d;
    logic [HOST_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [7:0]                 req_len_q,  req_len_d;
    logic                       id_err_q,   id_err_d;

    snap_id_slot_table #(
        .CORE_ID_WIDTH (CORE_ID_WIDTH),
        .HOST_ID_WIDTH (HOST_ID_WIDTH),
        .MAX_OUTST     (MAX_OUTST)
    ) u_slots (
        .clk           (ap_clk),
        .rst           (ap_rst),
        .req_id_i      (bus.core_req_id),
        .avail_o       (avail),
        .alloc_slot_o  (alloc_slot),
        .alloc_i       (accept),
        .rsp_slot_i    (bus.host_rsp_id),
        .rsp_bad_o     (rsp_bad),
        .rsp_core_id_o (rsp_core_id),
        .release_i     (rsp_release),
        .busy_o        (slots_busy)
    );

    assign bus.core_req_ready = !ap_rst && avail && (!req_vld_q || bus.host_req_ready);
    assign accept             = bus.core_req_valid && bus.core_req_ready;
    assign rsp_hs             = bus.host_rsp_valid && bus.core_rsp_ready;
    // Only a handshake on a live slot may move its count; stray responses just flag id_err.
    assign rsp_release        = rsp_hs && !rsp_bad && (bus.host_rsp_last || (RSP_HAS_LAST == 0));

    always_comb begin
        req_vld_d  = req_vld_q;
        req_id_d   = req_id_q;
        req_addr_d = req_addr_q;
        req_len_d  = req_len_q;
        if (accept) begin
            req_vld_d  = 1'b1;
            req_id_d   = alloc_slot;
            req_addr_d = {base_addr_hi, bus.core_req_addr};
            req_len_d  = 8'(bus.core_req_len);
        end else if (bus.host_req_ready) begin
            req_vld_d  = 1'b0;
        end
        id_err_d = id_err_q || (rsp_hs && rsp_bad);
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            req_vld_q  <= 1'b0;
            req_id_q   <= '0;
            req_addr_q <= '0;
            req_len_q  <= '0;
            id_err_q   <= 1'b0;
        end else begin
            req_vld_q  <= req_vld_d;
            req_id_q   <= req_id_d;
            req_addr_q <= req_addr_d;
            req_len_q  <= req_len_d;
            id_err_q   <= id_err_d;
        end
    end

    assign bus.host_req_valid = req_vld_q;
    assign bus.host_req_id    = req_id_q;
    assign bus.host_req_addr  = req_addr_q;
    assign bus.host_req_len   = req_len_q;
    assign bus.host_req_burst = AXI_BURST_INCR;
    assign bus.host_req_size  = HOST_SIZE;

    assign bus.core_rsp_valid = bus.host_rsp_valid;
    assign bus.host_rsp_ready = bus.core_rsp_ready;
    assign bus.core_rsp_id    = rsp_core_id;

    assign busy   = slots_busy || req_vld_q;
    assign id_err = id_err_q;

endmodule
